// File: rtl/regfile_bus_pkg.sv
// Shared types and constants for the register-file bus master.
package regfile_bus_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        W_DATA   = 3'd1,
        W_SETUP  = 3'd2,
        W_STROBE = 3'd3,
        R_ADDR   = 3'd4,
        R_WAIT   = 3'd5,
        R_SAMPLE = 3'd6,
        DONE     = 3'd7
    } state_e;

    localparam int unsigned READ_WAIT_MAX = 7;
    localparam int unsigned WAIT_W        = 3;

    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;

endpackage

// File: rtl/regfile_bus_master_burst_counter.sv
// Burst address register (wrapping increment) and down-counting beat register.
module burst_counter
    import regfile_bus_pkg::*;
#(
    parameter int unsigned Depth = 5
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [Depth-1:0] addr_i,
    input  logic [Depth-1:0] len_i,
    input  logic             step_i,
    output logic [Depth-1:0] addr_nxt_c_o,
    output logic             last_c_o
);

    logic [Depth-1:0] addr_q, addr_d;
    logic [Depth-1:0] cnt_q, cnt_d;

    // Address wraps naturally at 2**Depth; last beat is the one with a zero count.
    always_comb begin
        addr_d = addr_q;
        cnt_d  = cnt_q;
        if (load_i) begin
            addr_d = addr_i;
            cnt_d  = len_i;
        end else if (step_i) begin
            addr_d = addr_q + Depth'(1);
            cnt_d  = cnt_q - Depth'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            addr_q <= '0;
            cnt_q  <= '0;
        end else begin
            addr_q <= addr_d;
            cnt_q  <= cnt_d;
        end
    end

    assign addr_nxt_c_o = addr_d;
    assign last_c_o     = (cnt_q == '0);

endmodule

// File: rtl/regfile_bus_master.sv
// Initiator for the register_file cs_n/ws/oe bus: single or burst reads and writes
// requested over valid/ready, read data returned as one-cycle valid pulses.
module regfile_bus_master
    import regfile_bus_pkg::*;
#(
    parameter int unsigned Width    = 8,
    parameter int unsigned Depth    = 5,
    parameter int unsigned ReadWait = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic             req_write_i,
    input  logic [Depth-1:0] req_addr_i,
    input  logic [Depth-1:0] req_len_i,
    input  logic [Width-1:0] wdata_i,
    input  logic             wdata_valid_i,
    output logic             wdata_ready_o,
    output logic [Width-1:0] rdata_o,
    output logic             rdata_valid_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             cs_no,
    output logic             ws_o,
    output logic             oe_o,
    output logic [Depth-1:0] address_o,
    inout  wire  [Width-1:0] data_io
);

    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(ReadWait - 1);

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [Width-1:0]  wdata_q, rdata_q;
    logic              rdata_valid_q;
    logic              cs_n_q, cs_n_d, ws_q, ws_d, oe_q, oe_d, drv_q, drv_d;
    logic              busy_q, busy_d, done_q, done_d;
    logic              req_ready_q, req_ready_d, wready_q, wready_d;
    logic [Depth-1:0]  address_q, address_d;
    logic              load_c, step_c, last_c;
    logic [Depth-1:0]  addr_nxt_c;

    assign load_c = (state_q == IDLE) && req_valid_i;
    assign step_c = (state_q == W_STROBE) || (state_q == R_SAMPLE);

    burst_counter #(.Depth(Depth)) u_burst_counter (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .load_i       (load_c),
        .addr_i       (req_addr_i),
        .len_i        (req_len_i),
        .step_i       (step_c),
        .addr_nxt_c_o (addr_nxt_c),
        .last_c_o     (last_c)
    );

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        case (state_q)
            IDLE:     if (req_valid_i) state_d = (req_write_i == OP_WRITE) ? W_DATA : R_ADDR;
            W_DATA:   if (wdata_valid_i) state_d = W_SETUP;
            W_SETUP:  state_d = W_STROBE;
            W_STROBE: state_d = last_c ? DONE : W_DATA;
            R_ADDR: begin
                state_d = R_WAIT;
                wait_d  = WAIT_LOAD;
            end
            R_WAIT: begin
                if (wait_q == '0) state_d = R_SAMPLE;
                else              wait_d  = wait_q - WAIT_W'(1);
            end
            R_SAMPLE: state_d = last_c ? DONE : R_ADDR;
            DONE:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Output decode of the upcoming state, registered below so pins align with state_q
    always_comb begin
        cs_n_d      = (state_d == IDLE) || (state_d == DONE);
        ws_d        = (state_d == W_STROBE);
        oe_d        = (state_d == R_ADDR) || (state_d == R_WAIT) || (state_d == R_SAMPLE);
        drv_d       = (state_d == W_SETUP) || (state_d == W_STROBE);
        busy_d      = (state_d != IDLE);
        done_d      = (state_d == DONE);
        req_ready_d = (state_d == IDLE);
        wready_d    = (state_d == W_DATA);
        address_d   = address_q;
        if (oe_d || drv_d) address_d = addr_nxt_c;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wait_q        <= '0;
            wdata_q       <= '0;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
            cs_n_q        <= 1'b1;
            ws_q          <= 1'b0;
            oe_q          <= 1'b0;
            drv_q         <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            req_ready_q   <= 1'b1;
            wready_q      <= 1'b0;
            address_q     <= '0;
        end else begin
            wait_q        <= wait_d;
            if ((state_q == W_DATA) && wdata_valid_i) wdata_q <= wdata_i;
            if (state_q == R_SAMPLE) rdata_q <= data_io;
            rdata_valid_q <= (state_q == R_SAMPLE);
            cs_n_q        <= cs_n_d;
            ws_q          <= ws_d;
            oe_q          <= oe_d;
            drv_q         <= drv_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            req_ready_q   <= req_ready_d;
            wready_q      <= wready_d;
            address_q     <= address_d;
        end
    end

    assign data_io       = drv_q ? wdata_q : {Width{1'bz}};
    assign req_ready_o   = req_ready_q;
    assign wdata_ready_o = wready_q;
    assign rdata_o       = rdata_q;
    assign rdata_valid_o = rdata_valid_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign cs_no         = cs_n_q;
    assign ws_o          = ws_q;
    assign oe_o          = oe_q;
    assign address_o     = address_q;

endmodule
